mmio_test_ctrl: RTL and testbench

// - Memory-mapped simulation-control responder on the CPU data bus.
// - Firmware signals pass/fail, reads a 64-bit cycle counter and runs an in-RTL watchdog.
// - It is the CPU-side counterpart of the bench watchdog: the bench stops on test_done

---
 rtl/mmio_test_pkg.sv | 17 +
 rtl/mmio_test_ctrl_if.sv | 28 ++
 rtl/mmio_wdt_counter.sv | 47 ++++
 rtl/mmio_test_ctrl.sv | 146 ++++++++++++++
 tb/tb_mmio_test_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_test_pkg.sv
// Shared definitions for the MMIO simulation-control responder:
// register offsets, handshake FSM states and the watchdog kill code.
package mmio_test_pkg;

  localparam logic [4:0] OFF_TOHOST   = 5'h00;
  localparam logic [4:0] OFF_CYCLE_LO = 5'h04;
  localparam logic [4:0] OFF_CYCLE_HI = 5'h08;
  localparam logic [4:0] OFF_WDT_LOAD = 5'h0C;
  localparam logic [4:0] OFF_WDT_CTRL = 5'h10;
  localparam logic [4:0] OFF_SCRATCH  = 5'h14;

  typedef enum logic {S_IDLE, S_RESP} mmio_state_t;

  // Wide enough for any CPU_WIDTH in use; consumers slice the low bits.
  localparam logic [127:0] WDT_KILL_CODE = '1;

endpackage

// File: rtl/mmio_test_ctrl_if.sv
// CPU data-bus request/response channel between the CPU (master) and the
// simulation-control responder (slave).
interface mmio_test_ctrl_if #(
  parameter int CPU_WIDTH = 32
);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [CPU_WIDTH-1:0]   req_addr;
  logic [CPU_WIDTH-1:0]   req_wdata;
  logic [CPU_WIDTH/8-1:0] req_be;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [CPU_WIDTH-1:0]   rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mmio_wdt_counter.sv
// Firmware watchdog: reload value, enable bit and down-counter. Raises fire
// for the edge on which the count reaches (or already sits at) zero.
module mmio_wdt_counter
  import mmio_test_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int unsigned WDT_DEFAULT = 10000
) (
  input  logic             clk,
  input  logic             a_reset_n,
  input  logic             load_wr,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ctrl_wr,
  input  logic             ctrl_en,
  input  logic             halt,
  output logic [WIDTH-1:0] wdt_load,
  output logic             wdt_en,
  output logic             fire
);

  logic [WIDTH-1:0] count;

  // A count of 1 expires on the decrement; a count of 0 (loaded while
  // enabled) expires on the very next edge. A reload feeds the dog instead.
  always_comb begin
    fire = wdt_en && !halt && !load_wr && (count <= WIDTH'(1));
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      wdt_load <= WIDTH'(WDT_DEFAULT);
      count    <= WIDTH'(WDT_DEFAULT);
      wdt_en   <= 1'b0;
    end else begin
      if (load_wr) begin
        wdt_load <= load_val;
        count    <= load_val;
      end else if (wdt_en && !halt && (count != '0)) begin
        count <= count - WIDTH'(1);
      end
      if (ctrl_wr) begin
        wdt_en <= ctrl_en;
      end
    end
  end

endmodule

// File: rtl/mmio_test_ctrl.sv
// Memory-mapped simulation-control responder: pass/fail mailbox, 64-bit
// cycle counter with coherent LO/HI reads, scratch register and watchdog.
module mmio_test_ctrl
  import mmio_test_pkg::*;
#(
  parameter int                   CPU_WIDTH   = 32,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int unsigned          WDT_DEFAULT = 10000
) (
  input  logic                 clk,
  input  logic                 a_reset_n,
  mmio_test_ctrl_if.slave      bus,
  output logic                 test_done,
  output logic                 test_pass,
  output logic [CPU_WIDTH-2:0] test_code,
  output logic                 wdt_expired
);

  mmio_state_t          state;
  logic [63:0]          cycle_cnt;
  logic [31:0]          cycle_hi_snap;
  logic [CPU_WIDTH-1:0] scratch;
  logic [CPU_WIDTH-1:0] wdt_load;
  logic [CPU_WIDTH-1:0] wr_merged;
  logic [CPU_WIDTH-1:0] rd_val;
  logic [4:0]           off;
  logic                 accept, rd_err, wr_ok;
  logic                 tohost_fire, load_wr, ctrl_wr, ctrl_en, scratch_wr, lo_rd;
  logic                 wdt_en, wdt_fire;

  function automatic logic [CPU_WIDTH-1:0] be_merge(
    input logic [CPU_WIDTH-1:0]   old_val,
    input logic [CPU_WIDTH-1:0]   new_val,
    input logic [CPU_WIDTH/8-1:0] be
  );
    logic [CPU_WIDTH-1:0] r;
    r = old_val;
    for (int unsigned i = 0; i < CPU_WIDTH/8; i++) begin
      if (be[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    accept = (state == S_IDLE) && bus.req_valid;
    off    = bus.req_addr[4:0];
    rd_val = '0;
    rd_err = 1'b0;
    case (off)
      OFF_TOHOST:   rd_val = '0;
      OFF_CYCLE_LO: rd_val = CPU_WIDTH'(cycle_cnt[31:0]);
      OFF_CYCLE_HI: rd_val = CPU_WIDTH'(cycle_hi_snap);
      OFF_WDT_LOAD: rd_val = wdt_load;
      OFF_WDT_CTRL: rd_val = CPU_WIDTH'(wdt_en);
      OFF_SCRATCH:  rd_val = scratch;
      default:      rd_err = 1'b1;
    endcase
    if ((bus.req_addr[1:0] != 2'b00) ||
        (bus.req_addr[CPU_WIDTH-1:5] != BASE_ADDR[CPU_WIDTH-1:5])) begin
      rd_err = 1'b1;
    end
    wr_ok       = accept && bus.req_we && !rd_err;
    tohost_fire = wr_ok && (off == OFF_TOHOST) && bus.req_be[0] && bus.req_wdata[0] && !test_done;
    load_wr     = wr_ok && (off == OFF_WDT_LOAD);
    ctrl_wr     = wr_ok && (off == OFF_WDT_CTRL);
    scratch_wr  = wr_ok && (off == OFF_SCRATCH);
    lo_rd       = accept && !bus.req_we && !rd_err && (off == OFF_CYCLE_LO);
    ctrl_en     = bus.req_be[0] ? bus.req_wdata[0] : wdt_en;
    wr_merged   = be_merge((off == OFF_WDT_LOAD) ? wdt_load : scratch, bus.req_wdata, bus.req_be);
  end

  mmio_wdt_counter #(
    .WIDTH       (CPU_WIDTH),
    .WDT_DEFAULT (WDT_DEFAULT)
  ) u_wdt (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .load_wr   (load_wr),
    .load_val  (wr_merged),
    .ctrl_wr   (ctrl_wr),
    .ctrl_en   (ctrl_en),
    .halt      (test_done),
    .wdt_load  (wdt_load),
    .wdt_en    (wdt_en),
    .fire      (wdt_fire)
  );

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state         <= S_IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_RESP;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= rd_err;
            bus.rsp_rdata <= (bus.req_we || rd_err) ? '0 : rd_val;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // TOHOST is checked before the watchdog so a same-edge pass/fail report
  // is never overwritten by a kill.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      cycle_cnt     <= '0;
      cycle_hi_snap <= '0;
      scratch       <= '0;
      test_done     <= 1'b0;
      test_pass     <= 1'b0;
      test_code     <= '0;
      wdt_expired   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (lo_rd)      cycle_hi_snap <= cycle_cnt[63:32];
      if (scratch_wr) scratch       <= wr_merged;
      if (tohost_fire) begin
        test_done <= 1'b1;
        test_pass <= (bus.req_wdata[CPU_WIDTH-1:1] == '0);
        test_code <= bus.req_wdata[CPU_WIDTH-1:1];
      end else if (wdt_fire) begin
        test_done   <= 1'b1;
        test_pass   <= 1'b0;
        test_code   <= WDT_KILL_CODE[CPU_WIDTH-2:0];
        wdt_expired <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_test_ctrl.sv
// Self-checking bench for mmio_test_ctrl: a deadline-based reference model
// checked every cycle, plus directed transactions with literal expectations.
module tb_mmio_test_ctrl;

  localparam int          W       = 32;
  localparam logic [31:0] BASE    = 32'hFFFF_0000;
  localparam int unsigned WDT_DEF = 10000;

  logic        clk = 1'b0;
  logic        a_reset_n = 1'b1;
  logic        test_done, test_pass, wdt_expired;
  logic [30:0] test_code;

  mmio_test_ctrl_if #(.CPU_WIDTH(W)) bus ();

  mmio_test_ctrl #(
    .CPU_WIDTH   (W),
    .BASE_ADDR   (BASE),
    .WDT_DEFAULT (WDT_DEF)
  ) dut (
    .clk         (clk),
    .a_reset_n   (a_reset_n),
    .bus         (bus),
    .test_done   (test_done),
    .test_pass   (test_pass),
    .test_code   (test_code),
    .wdt_expired (wdt_expired)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Reference model: n = index of the clock edge since reset release.
  // The watchdog is modelled as an absolute deadline edge while enabled.
  int unsigned n = 0;
  bit          m_pend = 0, m_err = 0, m_en = 0;
  bit          m_done = 0, m_pass = 0, m_exp = 0;
  logic [31:0] m_rdata = '0, m_scratch = '0, m_load = WDT_DEF, m_rem = WDT_DEF, m_hi = '0;
  logic [30:0] m_code = '0;
  longint      m_deadline = 0;

  always @(posedge clk or negedge a_reset_n) begin
    bit         acc, good, wr, tohost, loadw, expire;
    logic [4:0] off;
    if (!a_reset_n) begin
      n = 0; m_pend = 0; m_err = 0; m_rdata = '0; m_scratch = '0;
      m_load = WDT_DEF; m_rem = WDT_DEF; m_en = 0; m_deadline = 0; m_hi = '0;
      m_done = 0; m_pass = 0; m_exp = 0; m_code = '0;
    end else begin
      n++;
      acc = !m_pend && bus.req_valid;
      if (m_pend && bus.rsp_ready) m_pend = 0;
      off    = bus.req_addr[4:0];
      good   = acc && (bus.req_addr[1:0] == 2'b00) && (off <= 5'h14) &&
               (bus.req_addr[31:5] == BASE[31:5]);
      wr     = good && bus.req_we;
      tohost = wr && (off == 5'h00) && bus.req_be[0] && bus.req_wdata[0] && !m_done;
      loadw  = wr && (off == 5'h0C);
      expire = m_en && !m_done && !loadw && (longint'(n) == m_deadline);
      if (acc) begin
        m_pend = 1; m_err = !good; m_rdata = '0;
        if (good && !bus.req_we) begin
          case (off)
            5'h04: begin m_rdata = n - 1; m_hi = '0; end
            5'h08: m_rdata = m_hi;
            5'h0C: m_rdata = m_load;
            5'h10: m_rdata = {31'b0, m_en};
            5'h14: m_rdata = m_scratch;
            default: m_rdata = '0;
          endcase
        end
        if (wr) begin
          case (off)
            5'h0C: begin
              m_load = merge(m_load, bus.req_wdata, bus.req_be);
              if (m_en) m_deadline = longint'(n) + ((m_load == 0) ? 64'd1 : longint'(m_load));
              else      m_rem = m_load;
            end
            5'h10: if (bus.req_be[0]) begin
              if (!m_en && bus.req_wdata[0])
                m_deadline = longint'(n) + ((m_rem == 0) ? 64'd1 : longint'(m_rem));
              else if (m_en && !bus.req_wdata[0])
                m_rem = 32'(m_deadline - longint'(n));
              m_en = bus.req_wdata[0];
            end
            5'h14: m_scratch = merge(m_scratch, bus.req_wdata, bus.req_be);
            default: ;
          endcase
        end
      end
      if (tohost) begin
        m_done = 1; m_code = bus.req_wdata[31:1]; m_pass = (m_code == 0);
      end else if (expire) begin
        m_done = 1; m_exp = 1; m_pass = 0; m_code = '1;
      end
    end
  end

  always @(negedge clk) begin
    check("test_done", test_done, m_done);
    check("test_pass", test_pass, m_pass);
    check("test_code", test_code, m_code);
    check("wdt_expired", wdt_expired, m_exp);
    check("rsp_valid", bus.rsp_valid, m_pend);
    check("req_ready", bus.req_ready, !m_pend);
    if (m_pend) begin
      check("rsp_rdata", bus.rsp_rdata, m_rdata);
      check("rsp_err", bus.rsp_err, m_err);
    end
  end

  task automatic do_reset();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 a_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #3 a_reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rdata, output logic err, output int unsigned acc_n);
    int k;
    rdata = '0; err = 1'b0; acc_n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_be = be; bus.rsp_ready = (hold == 0);
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.req_ready) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    acc_n = n; rdata = bus.rsp_rdata; err = bus.rsp_err;
    repeat (hold) @(negedge clk);
    bus.rsp_ready = 1'b1;
    k = 0;
    while (bus.rsp_valid && k < 20) begin @(negedge clk); k++; end
    if (bus.rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned an;
    int          k;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = BASE;
    bus.req_wdata = '0; bus.req_be = '0; bus.rsp_ready = 1'b1;

    do_reset();
    check("rst_done", test_done, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_expired", wdt_expired, 0);

    repeat (18) @(negedge clk);
    xact(0, BASE + 32'h04, '0, 4'hF, 0, rd, er, an);
    check("cycle_lo_range", (rd >= 20 && rd <= 22), 1);
    check("cycle_lo_err", er, 0);
    xact(0, BASE + 32'h08, '0, 4'hF, 0, rd, er, an);
    check("cycle_hi", rd, 0);

    xact(1, BASE, 32'h1, 4'hF, 0, rd, er, an);
    check("pass_done", test_done, 1);
    check("pass_pass", test_pass, 1);
    check("pass_code", test_code, 0);
    xact(1, BASE, 32'h7, 4'hF, 0, rd, er, an);
    check("sticky_code", test_code, 0);
    check("sticky_pass", test_pass, 1);

    do_reset();
    xact(1, BASE, 32'h55, 4'hF, 0, rd, er, an);
    check("fail_done", test_done, 1);
    check("fail_pass", test_pass, 0);
    check("fail_code", test_code, 31'h2A);

    do_reset();
    xact(1, BASE + 32'h0C, 32'd5, 4'hF, 0, rd, er, an);
    xact(0, BASE + 32'h0C, '0, 4'hF, 0, rd, er, an);
    check("wdt_load_rd", rd, 5);
    xact(1, BASE + 32'h10, 32'd1, 4'hF, 0, rd, er, an);
    k = 0;
    while (n < an + 4 && k < 20) begin @(negedge clk); k++; end
    check("wdt_before", wdt_expired, 0);
    @(negedge clk);
    check("wdt_expired", wdt_expired, 1);
    check("wdt_code", test_code, 31'h7FFF_FFFF);
    check("wdt_pass", test_pass, 0);
    xact(1, BASE, 32'h1, 4'hF, 0, rd, er, an);
    check("wdt_sticky", test_code, 31'h7FFF_FFFF);

    do_reset();
    xact(1, BASE + 32'h10, 32'd1, 4'hF, 0, rd, er, an);
    xact(1, BASE + 32'h0C, 32'd0, 4'hF, 0, rd, er, an);
    check("wdt_zero_load", wdt_expired, 1);

    do_reset();
    xact(1, BASE + 32'h14, 32'h0, 4'hF, 0, rd, er, an);
    xact(1, BASE + 32'h14, 32'hA5A5_A5A5, 4'b0011, 0, rd, er, an);
    xact(0, BASE + 32'h14, '0, 4'hF, 4, rd, er, an);
    check("scratch_merge", rd, 32'h0000_A5A5);
    xact(1, BASE + 32'h15, 32'hFFFF_FFFF, 4'hF, 0, rd, er, an);
    check("misaligned_wr_err", er, 1);
    xact(0, BASE + 32'h1C, '0, 4'hF, 0, rd, er, an);
    check("unmapped_err", er, 1);
    check("unmapped_rdata", rd, 0);
    xact(1, BASE + 32'h18, 32'h3, 4'hF, 0, rd, er, an);
    check("unmapped_wr_err", er, 1);
    xact(0, BASE + 32'h02, '0, 4'hF, 0, rd, er, an);
    check("misaligned_err", er, 1);
    xact(0, BASE + 32'h14, '0, 4'hF, 0, rd, er, an);
    check("scratch_kept", rd, 32'h0000_A5A5);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = BASE + 32'h14;
    bus.req_be = 4'hF; bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("resp_held", bus.rsp_valid, 1);
    #2 a_reset_n = 1'b0;
    #1;
    check("rst_drop_valid", bus.rsp_valid, 0);
    check("rst_drop_ready", bus.req_ready, 1);
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #3 a_reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
